// File: rtl/exp_pkg.sv
// Shared definitions for the streaming exponential datapath.
//   state_e  : engine FSM states
//   one_fx   : fixed-point 1.0 for a given fraction width
//   recip    : floor(2**frac_w / k), the Horner divisor table entry
//   out_w    : width of the shifted result bus
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic longint unsigned one_fx(int frac_w);
    return 64'd1 << frac_w;
  endfunction

  // k = 0 never indexes a real Horner step; return 0 so the table is total.
  function automatic longint unsigned recip(int k, int frac_w);
    if (k <= 0) return 64'd0;
    return (64'd1 << frac_w) / 64'(k);
  endfunction

  // Room for the largest shift of a Q(int_w).frac_w value.
  function automatic int out_w(int int_w, int frac_w, int shift_w);
    return int_w + frac_w + (1 << shift_w) - 1;
  endfunction

endpackage

// File: rtl/exp_stream_datapath_if.sv
// Operand/result stream bundle for exp_stream_datapath.
//   in_valid/in_ready/in_x/in_shift : operand handshake (source -> datapath)
//   out_valid/out_ready/out_data    : result handshake (datapath -> writer)
// slave  = datapath view, master = source/writer view.
interface exp_stream_datapath_if #(
  parameter int FRAC_W  = 16,
  parameter int INT_W   = 2,
  parameter int SHIFT_W = 2
);
  import exp_pkg::*;

  localparam int OUT_W = out_w(INT_W, FRAC_W, SHIFT_W);

  logic               in_valid;
  logic               in_ready;
  logic [FRAC_W-1:0]  in_x;
  logic [SHIFT_W-1:0] in_shift;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;

  modport slave (
    input  in_valid, in_x, in_shift, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_x, in_shift, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding packed {shift, x} operands.
//   clock, reset      : clock, async active-high reset
//   clear             : synchronous flush, wins over push/pop
//   push, wr_data     : write request (ignored when full)
//   pop, rd_data      : read request (ignored when empty); rd_data shows head
//   full, empty       : occupancy flags
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    do_push  = push & ~full  & ~clear;
    do_pop   = pop  & ~empty & ~clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PW bits wide, so DEPTH being a power of two gives wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // NOTE: non-blocking assignments make every flop sample the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/exp_stream_datapath.sv
// Streaming e^x engine: operands queue in sample_fifo, an FSM pops one at a
// time, runs TERMS-1 truncating Horner steps and holds the shifted result
// until the writer accepts it.
//   clock, reset : clock, async active-high reset
//   clear        : synchronous flush of FIFO and engine
//   io (slave)   : operand and result handshakes
//   busy         : engine not idle or operands still queued
module exp_stream_datapath
  import exp_pkg::*;
#(
  parameter int FRAC_W  = 16,
  parameter int INT_W   = 2,
  parameter int SHIFT_W = 2,
  parameter int TERMS   = 8,
  parameter int DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  exp_stream_datapath_if.slave  io,
  output logic                  busy
);

  localparam int AW    = INT_W + FRAC_W;   // accumulator width
  localparam int RW    = FRAC_W + 1;       // reciprocal width, holds 2**FRAC_W
  localparam int KW    = $clog2(TERMS);
  localparam int OUT_W = out_w(INT_W, FRAC_W, SHIFT_W);
  localparam logic [AW-1:0] ONE_AW = AW'(one_fx(FRAC_W));

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [KW-1:0]      k_q, k_d;
  logic [FRAC_W-1:0]  x_q, x_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SHIFT_W+FRAC_W-1:0] fifo_rd;

  // Constant divisor table; entry 0 is never selected by a running engine.
  logic [RW-1:0] recip_tbl [TERMS];
  for (genvar g = 0; g < TERMS; g++) begin : g_recip
    assign recip_tbl[g] = RW'(recip(g, FRAC_W));
  end

  assign fifo_push = io.in_valid & ~fifo_full & ~clear;

  sample_fifo #(
    .WIDTH (SHIFT_W + FRAC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .push    (fifo_push),
    .wr_data ({io.in_shift, io.in_x}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // One Horner step: acc' = ONE + ((((x*acc) >> F) * RECIP[k]) >> F).
  // Both products are formed at full width, then truncated by the shifts.
  logic [AW+FRAC_W-1:0] prod_p;
  logic [AW+RW-1:0]     prod_q;
  logic [AW-1:0]        p, q, acc_next;

  always_comb begin
    prod_p   = {{FRAC_W{1'b0}}, acc_q} * {{AW{1'b0}}, x_q};
    p        = AW'(prod_p >> FRAC_W);
    prod_q   = {{RW{1'b0}}, p} * {{AW{1'b0}}, recip_tbl[k_q]};
    q        = AW'(prod_q >> FRAC_W);
    acc_next = ONE_AW + q;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_d        = k_q;
    x_d        = x_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    fifo_pop   = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            x_d      = fifo_rd[FRAC_W-1:0];
            shift_d  = fifo_rd[FRAC_W +: SHIFT_W];
            acc_d    = ONE_AW;
            k_d      = KW'(TERMS - 1);
            state_d  = ITER;
          end
        end
        ITER: begin
          acc_d = acc_next;
          k_d   = k_q - KW'(1);
          if (k_q == KW'(1)) begin
            // Register the finished value so out_data is glitch-free in DONE.
            out_data_d = OUT_W'(acc_next) << shift_q;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (io.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      x_q        <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      x_q        <= x_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
    end
  end

  assign io.in_ready  = ~fifo_full;
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = out_data_q;
  assign busy         = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_exp_stream_datapath.sv
// Self-checking bench for exp_stream_datapath: directed vector table,
// multi-cycle corner sequences and a randomized scoreboard run.
module tb_exp_stream_datapath;

  localparam int FRAC_W  = 16;
  localparam int INT_W   = 2;
  localparam int SHIFT_W = 2;
  localparam int TERMS   = 8;
  localparam int DEPTH   = 4;
  localparam int LAT     = TERMS + 1;
  localparam int N_RAND  = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic busy;

  exp_stream_datapath_if #(.FRAC_W(FRAC_W), .INT_W(INT_W), .SHIFT_W(SHIFT_W)) io ();

  exp_stream_datapath #(
    .FRAC_W (FRAC_W),
    .INT_W  (INT_W),
    .SHIFT_W(SHIFT_W),
    .TERMS  (TERMS),
    .DEPTH  (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .io    (io),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint unsigned act,
                            input longint unsigned ref_v, input longint unsigned tol);
    longint unsigned diff;
    diff = (act > ref_v) ? act - ref_v : ref_v - act;
    n_cmp++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h +/- %0d", name, act, ref_v, tol);
    end
  endtask

  // Reference: truncated Taylor series of e^x evaluated by Horner's rule,
  // every multiply/divide rounding toward zero, then shifted.
  function automatic longint unsigned model_exp(input longint unsigned x, input int sh);
    longint unsigned one, acc, p;
    one = 64'd1 << FRAC_W;
    acc = one;
    for (int k = TERMS - 1; k >= 1; k--) begin
      p   = (x * acc) >> FRAC_W;
      acc = one + ((p * (one / 64'(k))) >> FRAC_W);
    end
    return acc << sh;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one operand to an idle datapath and waits for out_valid.
  // lat counts cycles from the accept cycle to the first out_valid cycle.
  task automatic send_one(input logic [FRAC_W-1:0] x, input logic [SHIFT_W-1:0] sh,
                          output longint unsigned data, output int lat);
    io.in_x     = x;
    io.in_shift = sh;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    data = io.out_data;
  endtask

  typedef struct {
    logic [FRAC_W-1:0]  x;
    logic [SHIFT_W-1:0] sh;
    longint unsigned    exp_data;
  } vec_t;

  vec_t              vecs [6];
  longint unsigned   d, held, expv;
  int                lat, hs, got, idx, first_block, n_sent, n_recv, seen;
  logic              stable, took;
  logic [FRAC_W-1:0] bx [6];
  logic [1:0]        bs [6];
  longint unsigned   exp_q [$];
  int                hs_cyc [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0000, 2'd0, 64'h10000};
    vecs[1] = '{16'h0000, 2'd3, 64'h80000};
    vecs[2] = '{16'h8000, 2'd0, model_exp(64'h8000, 0)};
    vecs[3] = '{16'h4000, 2'd1, model_exp(64'h4000, 1)};
    vecs[4] = '{16'hC000, 2'd2, model_exp(64'hC000, 2)};
    vecs[5] = '{16'h0001, 2'd0, model_exp(64'h0001, 0)};

    io.in_valid  = 1'b0;
    io.in_x      = '0;
    io.in_shift  = '0;
    io.out_ready = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", io.out_data, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Directed vectors, consumer always ready.
    io.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_one(vecs[i].x, vecs[i].sh, d, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      if (i == 2) check_near("vec_e_half", d, 64'h1A613, 16);
      tick();
      check($sformatf("vec%0d_valid_drop", i), io.out_valid, 0);
    end

    // Result held under back-pressure; exactly one handshake.
    io.out_ready = 1'b0;
    send_one(16'hFFFF, 2'd3, held, lat);
    check("hold_latency", lat, LAT);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!io.out_valid || io.out_data !== held) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_model", held, model_exp(64'hFFFF, 3));
    check_near("hold_e1", held >> 3, 64'h2B7E1, 32);
    io.out_ready = 1'b1;
    hs = 0;
    repeat (15) begin
      if (io.out_valid && io.out_ready) hs++;
      tick();
    end
    check("hold_one_handshake", hs, 1);

    // Burst of 6 pushes against a stalled consumer.
    io.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bx[i] = FRAC_W'($urandom);
      bs[i] = 2'(i);
    end
    exp_q.delete();
    idx = 0;
    first_block = -1;
    io.in_x = bx[0]; io.in_shift = bs[0]; io.in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      took = io.in_valid && io.in_ready;
      if (!took && first_block < 0) first_block = idx;
      if (took) exp_q.push_back(model_exp(bx[idx], bs[idx]));
      tick();
      if (took) begin
        idx++;
        if (idx < 6) begin
          io.in_x = bx[idx]; io.in_shift = bs[idx];
        end else begin
          io.in_valid = 1'b0;
        end
      end
    end
    check("burst_block_point", first_block, DEPTH + 1);
    check("burst_accepted", idx, DEPTH + 1);
    check("burst_in_ready_low", io.in_ready, 0);
    io.out_ready = 1'b1;
    got = 0;
    hs_cyc.delete();
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      took = io.in_valid && io.in_ready;
      if (io.out_valid) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF;
        check($sformatf("burst_data%0d", got), io.out_data, expv);
        hs_cyc.push_back(cyc);
        got++;
      end
      if (took) exp_q.push_back(model_exp(bx[5], bs[5]));
      tick();
      if (took) io.in_valid = 1'b0;
    end
    check("burst_count", got, 6);
    for (int i = 1; i < hs_cyc.size(); i++)
      check($sformatf("burst_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], LAT);
    tick();

    // Clear mid-ITER with 3 queued and a push in the same cycle.
    for (int i = 0; i < 4; i++) begin
      io.in_x = FRAC_W'($urandom); io.in_shift = 2'(i); io.in_valid = 1'b1;
      tick();
    end
    io.in_valid = 1'b0;
    check("clr_busy_before", busy, 1);
    clear = 1'b1;
    io.in_x = 16'h1234; io.in_valid = 1'b1;
    tick();
    clear = 1'b0; io.in_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_out_valid", io.out_valid, 0);
    check("clr_in_ready", io.in_ready, 1);
    seen = 0;
    repeat (30) begin
      if (io.out_valid || busy) seen++;
      tick();
    end
    check("clr_no_results", seen, 0);

    // Randomized traffic against the scoreboard.
    exp_q.delete();
    n_sent = 0;
    n_recv = 0;
    for (int cyc = 0; cyc < 3000 && n_recv < N_RAND; cyc++) begin
      if (!io.in_valid && n_sent < N_RAND && $urandom_range(0, 2) == 0) begin
        io.in_x = FRAC_W'($urandom); io.in_shift = SHIFT_W'($urandom_range(0, 3));
        io.in_valid = 1'b1;
      end
      io.out_ready = 1'($urandom_range(0, 1));
      took = io.in_valid && io.in_ready;
      if (io.out_valid && io.out_ready) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF;
        check("rand_data", io.out_data, expv);
        n_recv++;
      end
      if (took) begin
        exp_q.push_back(model_exp(io.in_x, int'(io.in_shift)));
        n_sent++;
      end
      tick();
      if (took) io.in_valid = 1'b0;
    end
    check("rand_count", n_recv, N_RAND);
    tick();
    check("rand_idle", busy, 0);

    // Asynchronous reset while a result is held in DONE.
    io.out_ready = 1'b0;
    send_one(16'h5555, 2'd2, d, lat);
    check("arst_pre_valid", io.out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", io.out_valid, 0);
    check("arst_out_data", io.out_data, 0);
    check("arst_in_ready", io.in_ready, 1);
    check("arst_busy", busy, 0);
    tick();
    reset = 1'b0;
    io.out_ready = 1'b1;
    seen = 0;
    repeat (15) begin
      if (io.out_valid) seen++;
      tick();
    end
    check("arst_lost", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
